// File: rtl/serial_ule_sequencer.sv
// rtl/serial_ule_sequencer.sv - serial unsigned comparator walking operands 2 bits per clock
//
// Purpose: compares two WIDTH-bit unsigned operands LSB-first through one 2-bit
// subtract-with-carry slice (b + ~a + carry), holding the inter-slice carry and a
// running equality flag in registers. Result is presented with a valid/ready handshake.
//
// Ports:
//   CLK      rising-edge clock
//   RESETN   synchronous active-low reset
//   I_VALID  request valid           I_READY  request accepted when high (IDLE only)
//   I0, I1   operands a, b           OP       0=ULE 1=ULT 2=UGE 3=UGT
//   O_VALID  result valid            O_READY  consumer accepts result
//   O        comparison result       EQ       a==b
//   BUSY     compare in progress or result pending
module serial_ule_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [1:0]       OP,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic             O,
   output logic             EQ,
   output logic             BUSY
);

   localparam int SLICE = 2;
   localparam int N     = WIDTH / SLICE;
   localparam int CW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_width
      $error("serial_ule_sequencer: WIDTH must be even and >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [1:0]       op_r;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             eq_acc;

   logic             c_out;
   logic             slice_eq;
   logic             fin_eq;
   logic             result;

   // Carry-out of b_s + ~a_s + carry; a 1 means a <= b over the slices seen so far.
   // Only the carry is kept, the difference bits are never needed.
   assign c_out    = ({1'b0, b_sr[1:0]} + {1'b0, ~a_sr[1:0]} + {2'b00, carry}) > 3'd3;
   assign slice_eq = (a_sr[1:0] == b_sr[1:0]);
   assign fin_eq   = eq_acc & slice_eq;

   // Result from the carry/equality that will be registered on the last slice edge.
   always_comb begin
      result = 1'b0;
      case (op_r)
         2'd0:    result = c_out;
         2'd1:    result = c_out & ~fin_eq;
         2'd2:    result = ~c_out | fin_eq;
         default: result = ~c_out;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state   <= S_IDLE;
         I_READY <= 1'b1;
         O_VALID <= 1'b0;
         O       <= 1'b0;
         EQ      <= 1'b0;
         BUSY    <= 1'b0;
         cnt     <= '0;
         carry   <= 1'b1;
         eq_acc  <= 1'b1;
         a_sr    <= '0;
         b_sr    <= '0;
         op_r    <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (I_VALID) begin
                  a_sr    <= I0;
                  b_sr    <= I1;
                  op_r    <= OP;
                  carry   <= 1'b1;
                  eq_acc  <= 1'b1;
                  cnt     <= '0;
                  I_READY <= 1'b0;
                  BUSY    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               carry  <= c_out;
               eq_acc <= fin_eq;
               a_sr   <= a_sr >> SLICE;
               b_sr   <= b_sr >> SLICE;
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  O_VALID <= 1'b1;
                  O       <= result;
                  EQ      <= fin_eq;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               // O and EQ deliberately hold their values after the handshake.
               if (O_READY) begin
                  O_VALID <= 1'b0;
                  BUSY    <= 1'b0;
                  I_READY <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ule_sequencer.sv
// tb/tb_serial_ule_sequencer.sv - self-checking bench for serial_ule_sequencer (WIDTH=8 and WIDTH=2)
module tb_serial_ule_sequencer;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       v8 = 1'b0, ordy8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [1:0] op8 = '0;
   logic       rdy8, ov8, o8, eq8, busy8;

   // WIDTH=2 instance
   logic       v2 = 1'b0, ordy2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic [1:0] op2 = '0;
   logic       rdy2, ov2, o2, eq2, busy2;

   serial_ule_sequencer #(.WIDTH(8)) dut8 (
      .CLK(clk), .RESETN(resetn), .I_VALID(v8), .I_READY(rdy8), .I0(a8), .I1(b8), .OP(op8),
      .O_VALID(ov8), .O_READY(ordy8), .O(o8), .EQ(eq8), .BUSY(busy8)
   );

   serial_ule_sequencer #(.WIDTH(2)) dut2 (
      .CLK(clk), .RESETN(resetn), .I_VALID(v2), .I_READY(rdy2), .I0(a2), .I1(b2), .OP(op2),
      .O_VALID(ov2), .O_READY(ordy2), .O(o2), .EQ(eq2), .BUSY(busy2)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         a;
      int         b;
      logic [1:0] op;
      int         stall;
      logic       exp_o;
      logic       exp_eq;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic comparison, independent of slicing.
   function automatic logic ref_o(input int a, input int b, input logic [1:0] op);
      case (op)
         2'd0:    return a <= b;
         2'd1:    return a <  b;
         2'd2:    return a >= b;
         default: return a >  b;
      endcase
   endfunction

   function automatic logic cur_rdy(input bit sel2);  return sel2 ? rdy2  : rdy8;  endfunction
   function automatic logic cur_ov(input bit sel2);   return sel2 ? ov2   : ov8;   endfunction
   function automatic logic cur_o(input bit sel2);    return sel2 ? o2    : o8;    endfunction
   function automatic logic cur_eq(input bit sel2);   return sel2 ? eq2   : eq8;   endfunction
   function automatic logic cur_busy(input bit sel2); return sel2 ? busy2 : busy8; endfunction

   task automatic drive(input bit sel2, input logic v, input int a, input int b, input logic [1:0] op);
      if (sel2) begin
         v2 = v; a2 = 2'(a); b2 = 2'(b); op2 = op;
      end else begin
         v8 = v; a8 = 8'(a); b8 = 8'(b); op8 = op;
      end
   endtask

   task automatic set_ordy(input bit sel2, input logic r);
      if (sel2) ordy2 = r; else ordy8 = r;
   endtask

   // One full request/response transaction, inputs driven and outputs sampled at negedge.
   task automatic run_cmp(input bit sel2, input int a, input int b, input logic [1:0] op,
                          input int stall, input logic exp_o, input logic exp_eq, input string name);
      int lat;
      int exp_lat;
      exp_lat = sel2 ? 1 : 4;
      @(negedge clk);
      chk({name, ".i_ready_idle"}, cur_rdy(sel2), 1);
      drive(sel2, 1'b1, a, b, op);
      @(negedge clk);
      // Garbage on the inputs while running must not matter.
      drive(sel2, 1'b0, int'($urandom), int'($urandom), 2'($urandom));
      chk({name, ".busy_after_accept"}, cur_busy(sel2), 1);
      chk({name, ".i_ready_running"}, cur_rdy(sel2), 0);
      lat = 0;
      while (!cur_ov(sel2) && lat < 20) begin
         drive(sel2, 1'($urandom), int'($urandom), int'($urandom), 2'($urandom));
         @(negedge clk);
         lat++;
      end
      chk({name, ".latency"}, lat, exp_lat);
      chk({name, ".o"}, cur_o(sel2), exp_o);
      chk({name, ".eq"}, cur_eq(sel2), exp_eq);
      for (int i = 0; i < stall; i++) begin
         drive(sel2, 1'($urandom), int'($urandom), int'($urandom), 2'($urandom));
         @(negedge clk);
         chk({name, ".stall_o_valid"}, cur_ov(sel2), 1);
         chk({name, ".stall_o"}, cur_o(sel2), exp_o);
         chk({name, ".stall_i_ready"}, cur_rdy(sel2), 0);
      end
      drive(sel2, 1'b0, 0, 0, 2'd0);
      set_ordy(sel2, 1'b1);
      @(negedge clk);
      set_ordy(sel2, 1'b0);
      chk({name, ".o_valid_drop"}, cur_ov(sel2), 0);
      chk({name, ".i_ready_back"}, cur_rdy(sel2), 1);
      chk({name, ".busy_drop"}, cur_busy(sel2), 0);
      chk({name, ".o_hold"}, cur_o(sel2), exp_o);
   endtask

   initial begin
      vecs.push_back('{32'h05, 32'h05, 2'd0, 0, 1'b1, 1'b1, "eq_ule"});
      vecs.push_back('{32'h05, 32'h05, 2'd1, 0, 1'b0, 1'b1, "eq_ult"});
      vecs.push_back('{32'h80, 32'h7F, 2'd0, 0, 1'b0, 1'b0, "msb_ule"});
      vecs.push_back('{32'h80, 32'h7F, 2'd3, 0, 1'b1, 1'b0, "msb_ugt"});
      vecs.push_back('{32'h00, 32'hFF, 2'd1, 0, 1'b1, 1'b0, "zero_ult"});
      vecs.push_back('{32'hFF, 32'h00, 2'd2, 0, 1'b1, 1'b0, "ff_uge"});
      vecs.push_back('{32'hFF, 32'h00, 2'd0, 0, 1'b0, 1'b0, "ff_ule"});
      vecs.push_back('{32'h12, 32'h34, 2'd0, 5, 1'b1, 1'b0, "backpressure"});

      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.i_ready8", rdy8, 1);
      chk("rst.o_valid8", ov8, 0);
      chk("rst.o8", o8, 0);
      chk("rst.eq8", eq8, 0);
      chk("rst.busy8", busy8, 0);
      chk("rst.o_valid2", ov2, 0);
      resetn = 1'b1;

      foreach (vecs[i])
         run_cmp(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].stall,
                 vecs[i].exp_o, vecs[i].exp_eq, vecs[i].name);

      // Reset in the second RUN cycle aborts the compare.
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h55, 32'h66, 2'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0, 2'd0);
      @(negedge clk);
      chk("abort.busy_before", busy8, 1);
      resetn = 1'b0;
      @(negedge clk);
      chk("abort.o_valid", ov8, 0);
      chk("abort.busy", busy8, 0);
      chk("abort.i_ready", rdy8, 1);
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort.no_result", ov8, 0);
      end
      run_cmp(1'b0, 32'h01, 32'h02, 2'd1, 0, 1'b1, 1'b0, "after_abort");

      // Random WIDTH=8 compares against the reference model.
      for (int i = 0; i < 30; i++) begin
         int ra, rb;
         logic [1:0] rop;
         ra  = int'($urandom_range(0, 255));
         rb  = (i % 4 == 0) ? ra : int'($urandom_range(0, 255));
         rop = 2'($urandom_range(0, 3));
         run_cmp(1'b0, ra, rb, rop, int'($urandom_range(0, 3)), ref_o(ra, rb, rop), ra == rb, "rand8");
      end

      // WIDTH=2 exhaustive with random stalls.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int op = 0; op < 4; op++)
               run_cmp(1'b1, a, b, 2'(op), int'($urandom_range(0, 2)),
                       ref_o(a, b, 2'(op)), a == b, "w2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_ule_sequencer.md
Name: serial_ule_sequencer

Overview:
Multi-cycle unsigned magnitude comparator that reuses one 2-bit subtract-with-carry slice, the same arithmetic as the 2-bit ULE (I1 + ~I0 + 1, carry-out = I0 <= I1). It walks WIDTH-bit operands LSB-first, one 2-bit slice per clock, and keeps the inter-slice carry in a register. Valid/ready handshakes on input and output let it sit between a request source and a consumer. It is the controller that lets narrow ice40 comparator hardware serve wide operands.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (odd is an elaboration error)
SLICE, 2, bits processed per cycle; fixed at 2, not user-overridable
N (derived), WIDTH/SLICE, number of slice cycles per compare

Ports:
CLK  input  1  rising-edge clock
RESETN  input  1  synchronous active-low reset
I_VALID  input  1  request valid
I_READY  output  1  block can accept a request
I0  input  WIDTH  operand a
I1  input  WIDTH  operand b
OP  input  2  0=ULE(a<=b), 1=ULT(a<b), 2=UGE(a>=b), 3=UGT(a>b)
O_VALID  output  1  result valid
O_READY  input  1  consumer accepts result
O  output  1  comparison result per latched OP
EQ  output  1  a==b
BUSY  output  1  high in RUN or DONE

Behaviour:
- One clock (CLK). Reset is synchronous and active-low (RESETN sampled on rising CLK).
- Reset values: state=IDLE, I_READY=1 (after reset deasserts), O_VALID=0, O=0, EQ=0, BUSY=0, cnt=0, carry=1, eq_acc=1, operand shift registers=0.
- States IDLE, RUN, DONE.
- IDLE:
  - I_READY=1.
  - On an edge with I_VALID=1, latch I0, I1 and OP.
  - Set carry=1, eq_acc=1, cnt=0, then go to RUN.
- RUN:
  - I_READY=0, BUSY=1.
  - Each cycle, take slices a_s=a[1:0] and b_s=b[1:0].
  - Compute {c_out,sum} = b_s + ~a_s + carry. Set carry<=c_out.
  - Set eq_acc <= eq_acc & (a_s==b_s).
  - Shift a and b right by 2. cnt <= cnt+1.
  - After the edge that processes slice cnt==N-1, go to DONE.
  - Subtract sum bits are discarded.
- DONE:
  - O_VALID=1.
  - O and EQ are registered and stable until handshake.
  - With C = final carry (1 means a<=b):
    - ULE: O = C
    - ULT: O = C & ~eq_acc
    - UGE: O = ~C | eq_acc
    - UGT: O = ~C
  - EQ = eq_acc.
  - On an edge with O_READY=1, go to IDLE. O_VALID drops the next cycle; O and EQ hold their last values.
- Latency: request accepted at edge k, so O_VALID is high after edge k+N (N=4 for WIDTH=8). Minimum initiation interval is N+2 cycles.
- I_READY depends only on state (no combinational path from O_READY). A new request is never accepted in the same cycle as output handshake.
- I_VALID, I0, I1 and OP are ignored outside IDLE. Input changes during RUN do not affect the result.
- O_READY is ignored outside DONE. O_VALID never drops without a handshake, except on reset.
- WIDTH=2: RUN lasts exactly 1 cycle.
- Reset mid-RUN or mid-DONE:
  - Aborts the compare; no result is emitted.
  - All registers return to their reset values on that edge.
- cnt width is clog2(N), minimum 1. cnt wraps to 0 when leaving RUN.

Test Plan:
1. WIDTH=8, I0=0x05, I1=0x05, OP=0 -> O_VALID exactly 4 cycles after accept; O=1, EQ=1. Repeat with OP=1 -> O=0.
2. I0=0x80, I1=0x7F: OP=0 -> O=0; OP=3 -> O=1; EQ=0 in both (exercises carry across the MSB slice).
3. I0=0x00, I1=0xFF, OP=1 -> O=1. Then I0=0xFF, I1=0x00, OP=2 -> O=1, and OP=0 -> O=0.
4. Backpressure: I0=0x12, I1=0x34, OP=0; O_READY=0 for 5 cycles.
   - O_VALID=1 and O=1 held throughout.
   - I_READY=0 throughout; toggling I_VALID with new operands is ignored.
   - O_READY=1 -> IDLE next cycle, then the next request is accepted normally.
5. RESETN=0 in the 2nd RUN cycle:
   - Next cycle state=IDLE, O_VALID=0, BUSY=0.
   - No result appears.
   - Subsequent I0=0x01, I1=0x02, OP=1 -> O=1.
6. WIDTH=2: exhaustive 16 operand pairs x 4 OPs with random O_READY stalls; compare against a reference model; latency is 1 cycle every time.
